ifetch: RTL and testbench



---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 72 +++++++
 rtl/ifetch.sv | 102 ++++++++++
 tb/tb_ifetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants and helpers for the DLX instruction-fetch stage.
package ifetch_pkg;

   localparam int unsigned PC_WIDTH_DEF   = 32;
   localparam int unsigned INST_WIDTH_DEF = 32;
   localparam int unsigned RESET_PC_DEF   = 0;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned IMEM_LATENCY   = 2;
   localparam int unsigned INST_BYTES     = 4;

   typedef enum logic [1:0] {
      FIFO_IDLE = 2'b00,
      FIFO_POP  = 2'b01,
      FIFO_PUSH = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Shift-register FIFO; entry 0 is always the head, so the read data comes straight from a flop.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic             full, do_push, do_pop;
   fifo_op_e         op;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign op      = fifo_op_e'({do_push, do_pop});

   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         unique case (op)
            FIFO_PUSH: begin
               for (int unsigned i = 0; i < DEPTH; i++)
                  if (CNT_W'(i) == count_q) data_d[i] = wdata;
               count_d = count_q + CNT_W'(1);
            end
            FIFO_POP: begin
               for (int unsigned i = 0; i < DEPTH - 1; i++) data_d[i] = data_q[i+1];
               count_d = count_q - CNT_W'(1);
            end
            FIFO_BOTH: begin
               // shift first, then land the new word in the slot just vacated at the tail
               for (int unsigned i = 0; i < DEPTH - 1; i++) data_d[i] = data_q[i+1];
               for (int unsigned i = 0; i < DEPTH; i++)
                  if (CNT_W'(i) == count_q - CNT_W'(1)) data_d[i] = wdata;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign head  = data_q[0];
   assign count = count_q;

endmodule

// File: rtl/ifetch.sv
// DLX fetch stage: owns the fetch PC, tracks the fixed imem latency with in-flight slots,
// buffers returned words for decode and squashes wrong-path work on redirect.
module ifetch
   import ifetch_pkg::*;
#(
   parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
   parameter int unsigned         INST_WIDTH = INST_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_DEF),
   parameter int unsigned         FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [PC_WIDTH-1:0]   imem_pc,
   input  logic [INST_WIDTH-1:0] imem_inst,
   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   input  logic                  id_ready,
   output logic                  id_valid,
   output logic [INST_WIDTH-1:0] id_inst,
   output logic [PC_WIDTH-1:0]   id_pc,
   output logic [PC_WIDTH-1:0]   id_pc_plus4
);

   localparam int unsigned CNT_W   = cnt_width(FIFO_DEPTH);
   localparam int unsigned CRD_W   = CNT_W + 1;
   localparam int unsigned ENTRY_W = INST_WIDTH + PC_WIDTH;

   logic [PC_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
   logic [IMEM_LATENCY-1:0] slot_valid_q, slot_valid_d;
   logic [PC_WIDTH-1:0]     slot_pc_q [IMEM_LATENCY];
   logic [PC_WIDTH-1:0]     slot_pc_d [IMEM_LATENCY];

   logic                    issue, fifo_push, fifo_pop, fifo_flush, fifo_empty;
   logic [CNT_W-1:0]        fifo_count;
   logic [CRD_W-1:0]        credits_used;
   logic [ENTRY_W-1:0]      fifo_wdata, fifo_head;
   logic [1:0]              unused_redirect_lsbs;

   // Buffered words plus every word still in flight must fit; a same-cycle pop earns no credit.
   always_comb begin
      credits_used = CRD_W'(fifo_count);
      for (int unsigned i = 0; i < IMEM_LATENCY; i++)
         credits_used = credits_used + CRD_W'(slot_valid_q[i]);
      issue = !redirect_valid && (credits_used < CRD_W'(FIFO_DEPTH));
   end

   always_comb begin
      slot_valid_d[0] = issue;
      slot_pc_d[0]    = fetch_pc_q;
      for (int unsigned i = 1; i < IMEM_LATENCY; i++) begin
         slot_valid_d[i] = slot_valid_q[i-1];
         slot_pc_d[i]    = slot_pc_q[i-1];
      end
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         slot_valid_d = '0;
         fetch_pc_d   = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + PC_WIDTH'(INST_BYTES);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q   <= RESET_PC;
         slot_valid_q <= '0;
         for (int unsigned i = 0; i < IMEM_LATENCY; i++) slot_pc_q[i] <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         slot_valid_q <= slot_valid_d;
         slot_pc_q    <= slot_pc_d;
      end
   end

   assign unused_redirect_lsbs = redirect_pc[1:0];

   assign fifo_flush = redirect_valid;
   assign fifo_push  = slot_valid_q[IMEM_LATENCY-1] && !redirect_valid;
   assign fifo_pop   = id_valid && id_ready && !redirect_valid;
   assign fifo_wdata = {imem_inst, slot_pc_q[IMEM_LATENCY-1]};

   ifetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .wdata (fifo_wdata),
      .head  (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   assign imem_pc          = fetch_pc_q;
   assign id_valid         = !fifo_empty;
   assign {id_inst, id_pc} = fifo_head;
   assign id_pc_plus4      = id_pc + PC_WIDTH'(INST_BYTES);

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a two-stage imem model keyed by address, directed stall/redirect/reset scenarios.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_pc;
   logic [31:0] imem_inst;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b1;
   logic        id_valid;
   logic [31:0] id_inst, id_pc, id_pc_plus4;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;
   exp_t exp_q[$];

   logic        stall_q = 1'b0;
   logic [31:0] prev_pc, prev_inst;
   logic [31:0] mem_r1 = '0, mem_r2 = '0;

   always #5 clk = ~clk;

   ifetch #(
      .PC_WIDTH   (32),
      .INST_WIDTH (32),
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_pc        (imem_pc),
      .imem_inst      (imem_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .id_valid       (id_valid),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4)
   );

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h20620003;
         32'h4:   return 32'h2041ffff;
         32'h8:   return 32'h00222020;
         32'hC:   return 32'h00c53820;
         default: return {~a[15:0], a[15:0]};
      endcase
   endfunction

   always @(posedge clk) begin
      mem_r1 <= imem_word(imem_pc);
      mem_r2 <= mem_r1;
   end
   assign imem_inst = mem_r2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_stream(input logic [31:0] start, input int n);
      logic [31:0] p;
      exp_t e;
      p = start;
      for (int i = 0; i < n; i++) begin
         e.pc   = p;
         e.inst = imem_word(p);
         exp_q.push_back(e);
         p = p + 32'd4;
      end
   endtask

   // Monitor: compares every accepted instruction against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && stall_q) begin
         chk("stall_valid", {31'b0, id_valid}, 32'd1);
         chk("stall_pc", id_pc, prev_pc);
         chk("stall_inst", id_inst, prev_inst);
      end
      if (rst_n && id_valid && id_ready && !redirect_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got pc %h with empty scoreboard", id_pc);
         end else begin
            e = exp_q.pop_front();
            chk("out_pc", id_pc, e.pc);
            chk("out_inst", id_inst, e.inst);
            chk("out_pc_plus4", id_pc_plus4, e.pc + 32'd4);
         end
      end
      if (rst_n && dut.u_fifo.push)
         chk("no_push_when_full", {31'b0, dut.u_fifo.full}, 32'd0);
      stall_q   <= rst_n && id_valid && !id_ready && !redirect_valid;
      prev_pc   <= id_pc;
      prev_inst <= id_inst;
   end

   // Called just after reset release; the following negedge belongs to cycle 0.
   task automatic check_restart(input string tag);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("%s_valid_c%0d", tag, k), {31'b0, id_valid}, (k == 3) ? 32'd1 : 32'd0);
         if (k == 0) chk($sformatf("%s_imem_pc_c0", tag), imem_pc, 32'h0);
         if (k == 1) chk($sformatf("%s_imem_pc_c1", tag), imem_pc, 32'h4);
         if (k == 3) chk($sformatf("%s_first_pc", tag), id_pc, 32'h0);
      end
   endtask

   // Called #1 after a posedge: redirect_valid is high for exactly one cycle.
   task automatic do_redirect(input logic [31:0] tgt, input logic [31:0] exp_pc);
      exp_q.delete();
      push_stream(exp_pc, 64);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
   endtask

   task automatic check_target(input string tag, input logic [31:0] exp_pc);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("%s_valid_n%0d", tag, k), {31'b0, id_valid}, (k == 4) ? 32'd1 : 32'd0);
         if (k == 1) chk($sformatf("%s_imem_pc", tag), imem_pc, exp_pc);
         if (k == 4) chk($sformatf("%s_pc", tag), id_pc, exp_pc);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_id_inst", id_inst, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);
      chk("rst_imem_pc", imem_pc, 32'h0);

      // Stream from reset; cycle k presents imem_pc = 4k.
      @(posedge clk);
      #1;
      exp_q.delete();
      push_stream(32'h0, 64);
      rst_n = 1'b1;
      check_restart("boot");

      // Stall cycles 8..13.
      repeat (5) @(posedge clk);
      #1;
      id_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) chk("stall_imem_pc_c8", imem_pc, 32'h20);
         if (k == 1) chk("stall_imem_pc_c9", imem_pc, 32'h24);
         if (k == 5) begin
            chk("stall_imem_pc_c13", imem_pc, 32'h24);
            chk("stall_head_pc", id_pc, 32'h14);
         end
      end
      @(posedge clk);
      #1;
      id_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // Redirect with one buffered word and two in flight.
      do_redirect(32'h40, 32'h40);
      check_target("redir40", 32'h40);

      // Stall until full, then two back-to-back redirects; only 0x80 survives.
      @(posedge clk);
      #1;
      id_ready = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("full_count", {29'b0, dut.u_fifo.count}, 32'd4);
      @(posedge clk);
      #1;
      exp_q.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      @(posedge clk);
      #1;
      push_stream(32'h80, 64);
      redirect_pc = 32'h80;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      check_target("redir80", 32'h80);

      // Misaligned target and wrap-around target.
      repeat (3) @(posedge clk);
      #1;
      do_redirect(32'h43, 32'h40);
      check_target("redir43", 32'h40);
      @(posedge clk);
      #1;
      do_redirect(32'hFFFFFFFC, 32'hFFFFFFFC);
      check_target("redir_wrap", 32'hFFFFFFFC);
      chk("wrap_pc_plus4", id_pc_plus4, 32'h0);
      @(negedge clk);
      chk("wrap_next_pc", id_pc, 32'h0);

      // Asynchronous reset pulse between edges.
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_id_valid", {31'b0, id_valid}, 32'd0);
      chk("arst_imem_pc", imem_pc, 32'h0);
      chk("arst_id_pc", id_pc, 32'h0);
      exp_q.delete();
      push_stream(32'h0, 64);
      #1;
      rst_n = 1'b1;
      check_restart("arst");
      repeat (6) @(posedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
